// File: rtl/cal_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cal_pkg
// Purpose  : Shared types and constants for the calibration sweep sequencer.
// Revision : 1.0  initial release
// ============================================================================
package cal_pkg;

    localparam int CAL_PARA_W          = 6;
    localparam int CAL_GAP_CYC_DEFAULT = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_SETTLE = 3'd2,
        ST_RUN    = 3'd3,
        ST_GAP    = 3'd4
    } cal_sweep_state_t;

    function automatic int cal_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cal_sweep_timer.sv
`default_nettype none
// ============================================================================
// Module   : cal_sweep_timer
// Purpose  : Loadable down-counter; a load of N makes expire high in the Nth
//            cycle after the load (N >= 1).
// Revision : 1.0  initial release
// ============================================================================
module cal_sweep_timer #(
    parameter int WIDTH = 16
) (
    input  logic             clk_sys,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] value,
    output logic             expire
);

    logic [WIDTH-1:0] r_cnt;

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= value;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign expire = (r_cnt <= WIDTH'(1));

endmodule
`default_nettype wire

// File: rtl/cal_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cal_sweep_ctrl
// Purpose  : Calibration sweep sequencer stepping the divider setting from a
//            start to a stop value. Build option CAL_SWEEP_LOOP_EN repeats
//            the sweep until aborted.
// Revision : 1.0  initial release
// ============================================================================
module cal_sweep_ctrl
    import cal_pkg::*;
#(
    parameter int DWELL_W  = 16,
    parameter int SETTLE_W = 8,
    parameter int GAP_CYC  = CAL_GAP_CYC_DEFAULT
) (
    input  logic                  clk_sys,
    input  logic                  rst_n,
    input  logic                  sweep_go,
    input  logic                  sweep_abort,
    input  logic [CAL_PARA_W-1:0] para_start,
    input  logic [CAL_PARA_W-1:0] para_stop,
    input  logic [CAL_PARA_W-1:0] para_step,
    input  logic [DWELL_W-1:0]    dwell,
    input  logic [SETTLE_W-1:0]   settle,
    output logic                  cal_load,
    output logic [CAL_PARA_W-1:0] cal_para,
    output logic                  cal_start,
    output logic                  busy,
    output logic                  done,
    output logic [CAL_PARA_W-1:0] point_idx
);

    localparam int TMR_W = cal_max(DWELL_W, SETTLE_W);

    cal_sweep_state_t r_state, w_state_nxt;

    logic [CAL_PARA_W-1:0] r_start, r_stop, r_step;
    logic [DWELL_W-1:0]    r_dwell;
    logic [SETTLE_W-1:0]   r_settle;
    logic [CAL_PARA_W-1:0] r_cur, w_cur_nxt;
    logic [CAL_PARA_W-1:0] r_point_idx, w_idx_nxt;
    logic [CAL_PARA_W-1:0] r_cal_para, w_para_nxt;
    logic                  r_cal_load, w_load_nxt;
    logic                  r_cal_start, w_start_nxt;
    logic                  r_busy, w_busy_nxt;
    logic                  r_done, w_done_nxt;
    logic                  w_cfg_latch;

    logic                  w_tmr_load;
    logic [TMR_W-1:0]      w_tmr_value;
    logic                  w_tmr_expire;

    logic [CAL_PARA_W:0]   w_sum;
    logic                  w_last;
    logic [TMR_W-1:0]      w_dwell_eff;
    logic [CAL_PARA_W-1:0] w_idx_inc;

    // Extra bit catches wrap past the top of the 6-bit divider range.
    assign w_sum       = {1'b0, r_cur} + {1'b0, r_step};
    assign w_last      = (r_step == '0) || w_sum[CAL_PARA_W] ||
                         (w_sum[CAL_PARA_W-1:0] > r_stop);
    assign w_dwell_eff = (r_dwell == '0) ? TMR_W'(1) : TMR_W'(r_dwell);
    assign w_idx_inc   = (r_point_idx == '1) ? r_point_idx
                                             : r_point_idx + {{(CAL_PARA_W-1){1'b0}}, 1'b1};

    cal_sweep_timer #(
        .WIDTH (TMR_W)
    ) u_timer (
        .clk_sys (clk_sys),
        .rst_n   (rst_n),
        .load    (w_tmr_load),
        .value   (w_tmr_value),
        .expire  (w_tmr_expire)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_cur_nxt   = r_cur;
        w_idx_nxt   = r_point_idx;
        w_para_nxt  = r_cal_para;
        w_load_nxt  = 1'b0;
        w_start_nxt = 1'b0;
        w_done_nxt  = 1'b0;
        w_cfg_latch = 1'b0;
        w_tmr_load  = 1'b0;
        w_tmr_value = '0;

        case (r_state)
            ST_IDLE: begin
                if (sweep_go) begin
                    w_cfg_latch = 1'b1;
                    w_cur_nxt   = para_start;
                    w_idx_nxt   = '0;
                    w_para_nxt  = para_start;
                    w_load_nxt  = 1'b1;
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                w_tmr_load = 1'b1;
                if (r_settle != '0) begin
                    w_tmr_value = TMR_W'(r_settle);
                    w_state_nxt = ST_SETTLE;
                end else begin
                    w_tmr_value = w_dwell_eff;
                    w_start_nxt = 1'b1;
                    w_state_nxt = ST_RUN;
                end
            end
            ST_SETTLE: begin
                if (w_tmr_expire) begin
                    w_tmr_load  = 1'b1;
                    w_tmr_value = w_dwell_eff;
                    w_start_nxt = 1'b1;
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_tmr_expire) begin
                    w_tmr_load  = 1'b1;
                    w_tmr_value = TMR_W'(GAP_CYC);
                    w_state_nxt = ST_GAP;
                end else begin
                    w_start_nxt = 1'b1;
                end
            end
            ST_GAP: begin
                if (w_tmr_expire) begin
                    if (w_last) begin
                        w_done_nxt = 1'b1;
`ifdef CAL_SWEEP_LOOP_EN
                        w_cur_nxt   = r_start;
                        w_idx_nxt   = '0;
                        w_para_nxt  = r_start;
                        w_load_nxt  = 1'b1;
                        w_state_nxt = ST_LOAD;
`else
                        w_state_nxt = ST_IDLE;
`endif
                    end else begin
                        w_cur_nxt   = w_sum[CAL_PARA_W-1:0];
                        w_idx_nxt   = w_idx_inc;
                        w_para_nxt  = w_sum[CAL_PARA_W-1:0];
                        w_load_nxt  = 1'b1;
                        w_state_nxt = ST_LOAD;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        // Abort beats everything, including a simultaneous go in IDLE.
        if (sweep_abort) begin
            w_state_nxt = ST_IDLE;
            w_cur_nxt   = r_cur;
            w_idx_nxt   = r_point_idx;
            w_para_nxt  = r_cal_para;
            w_load_nxt  = 1'b0;
            w_start_nxt = 1'b0;
            w_done_nxt  = 1'b0;
            w_cfg_latch = 1'b0;
            w_tmr_load  = 1'b0;
        end

        w_busy_nxt = (w_state_nxt != ST_IDLE);
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_start     <= '0;
            r_stop      <= '0;
            r_step      <= '0;
            r_dwell     <= '0;
            r_settle    <= '0;
            r_cur       <= '0;
            r_point_idx <= '0;
            r_cal_para  <= '0;
            r_cal_load  <= 1'b0;
            r_cal_start <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cur       <= w_cur_nxt;
            r_point_idx <= w_idx_nxt;
            r_cal_para  <= w_para_nxt;
            r_cal_load  <= w_load_nxt;
            r_cal_start <= w_start_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
            if (w_cfg_latch) begin
                r_start  <= para_start;
                r_stop   <= para_stop;
                r_step   <= para_step;
                r_dwell  <= dwell;
                r_settle <= settle;
            end
        end
    end

    assign cal_load  = r_cal_load;
    assign cal_para  = r_cal_para;
    assign cal_start = r_cal_start;
    assign busy      = r_busy;
    assign done      = r_done;
    assign point_idx = r_point_idx;

endmodule
`default_nettype wire

// File: tb/tb_cal_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_cal_sweep_ctrl
// Purpose  : Self-checking bench for cal_sweep_ctrl with a per-cycle trace
//            model and literal checks of sweep traces.
// Revision : 1.0  initial release
// ============================================================================
module tb_cal_sweep_ctrl;

    localparam int GAP = 4;

    logic        clk_sys = 1'b0;
    logic        rst_n = 1'b0;
    logic        sweep_go = 1'b0;
    logic        sweep_abort = 1'b0;
    logic [5:0]  para_start = '0, para_stop = '0, para_step = '0;
    logic [15:0] dwell = '0;
    logic [7:0]  settle = '0;
    logic        cal_load, cal_start, busy, done;
    logic [5:0]  cal_para, point_idx;

    cal_sweep_ctrl #(
        .DWELL_W  (16),
        .SETTLE_W (8),
        .GAP_CYC  (GAP)
    ) dut (
        .clk_sys     (clk_sys),
        .rst_n       (rst_n),
        .sweep_go    (sweep_go),
        .sweep_abort (sweep_abort),
        .para_start  (para_start),
        .para_stop   (para_stop),
        .para_step   (para_step),
        .dwell       (dwell),
        .settle      (settle),
        .cal_load    (cal_load),
        .cal_para    (cal_para),
        .cal_start   (cal_start),
        .busy        (busy),
        .done        (done),
        .point_idx   (point_idx)
    );

    always #5 clk_sys = ~clk_sys;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model: expected per-cycle trace ---------
    typedef struct {
        bit load; int para; bit start; bit busy; bit done; int idx;
    } exp_t;

    exp_t q[$];
    bit   m_active = 0;
    bit   m_loop = 0;
    int   m_start, m_stop, m_step, m_dwell, m_settle;
    int   e_para = 0, e_idx = 0;
    bit   idx_known = 1;

    initial begin
`ifdef CAL_SWEEP_LOOP_EN
        m_loop = 1;
`endif
    end

    function automatic exp_t mk(bit l, int p, bit s, bit b, bit d, int i);
        exp_t e;
        e.load = l; e.para = p; e.start = s; e.busy = b; e.done = d; e.idx = i;
        return e;
    endfunction

    task automatic gen_pass(input bit done_first);
        int cur, idx, d, nxt;
        bit first;
        cur = m_start; idx = 0; first = 1;
        d = (m_dwell == 0) ? 1 : m_dwell;
        forever begin
            q.push_back(mk(1, cur, 0, 1, done_first && first, idx));
            first = 0;
            repeat (m_settle) q.push_back(mk(0, cur, 0, 1, 0, idx));
            repeat (d)        q.push_back(mk(0, cur, 1, 1, 0, idx));
            repeat (GAP)      q.push_back(mk(0, cur, 0, 1, 0, idx));
            nxt = cur + m_step;
            if (m_step == 0 || nxt > 63 || nxt > m_stop) break;
            cur = nxt;
            idx = (idx < 63) ? idx + 1 : 63;
        end
        if (!m_loop) begin
            q.push_back(mk(0, cur, 0, 0, 1, idx));
            m_active = 0;
        end
    endtask

    always @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            q.delete(); m_active = 0; e_para = 0; e_idx = 0; idx_known = 1;
        end else if (sweep_abort) begin
            q.delete(); m_active = 0; idx_known = 0;
        end else if (!m_active && q.size() == 0 && sweep_go) begin
            m_start = para_start; m_stop = para_stop; m_step = para_step;
            m_dwell = dwell; m_settle = settle;
            m_active = 1;
            gen_pass(0);
        end else if (m_active && q.size() == 0) begin
            gen_pass(1);
        end
    end

    always @(posedge clk_sys) cyc++;

    // Compare process: every cycle, DUT vs model.
    always @(negedge clk_sys) begin
        exp_t e;
        bit   bad;
        if (q.size() > 0) begin
            e = q.pop_front();
            e_para = e.para; e_idx = e.idx; idx_known = 1;
        end else begin
            e = mk(0, e_para, 0, 0, 0, e_idx);
        end
        bad = ({cal_load, cal_start, busy, done} !== {e.load, e.start, e.busy, e.done}) ||
              (cal_para !== 6'(e.para)) || (idx_known && point_idx !== 6'(e.idx));
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL trace cyc=%0d: got load=%0b para=%0d start=%0b busy=%0b done=%0b idx=%0d expected load=%0b para=%0d start=%0b busy=%0b done=%0b idx=%0d",
                     cyc, cal_load, cal_para, cal_start, busy, done, point_idx,
                     e.load, e.para, e.start, e.busy, e.done, e.idx);
        end
    end

    // ---------------- monitor for literal checks -------------------------
    int mon_loads[$], mon_load_cyc[$], mon_rise[$], mon_len[$];
    int mon_done = 0, run_len = 0;
    bit prev_start = 0;

    always @(negedge clk_sys) begin
        if (cal_load) begin
            mon_loads.push_back(int'(cal_para));
            mon_load_cyc.push_back(cyc);
        end
        if (done) mon_done++;
        if (cal_start) begin
            if (!prev_start) mon_rise.push_back(cyc);
            run_len++;
        end else if (prev_start) begin
            mon_len.push_back(run_len);
            run_len = 0;
        end
        prev_start = cal_start;
    end

    task automatic mon_clear();
        mon_loads.delete(); mon_load_cyc.delete(); mon_rise.delete(); mon_len.delete();
        mon_done = 0;
    endtask

    // ---------------- stimulus helpers -----------------------------------
    task automatic drive_go(input int s, input int p, input int st, input int dw, input int se);
        @(posedge clk_sys); #2;
        mon_clear();
        para_start = 6'(s); para_stop = 6'(p); para_step = 6'(st);
        dwell = 16'(dw); settle = 8'(se);
        sweep_go = 1'b1;
        @(posedge clk_sys); #2;
        sweep_go = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            @(negedge clk_sys);
            n++;
        end
        chk("sweep_timeout", int'(n >= budget), 0);
        @(negedge clk_sys);
    endtask

    initial begin
        int n;
        bit seen_busy;

        repeat (3) @(posedge clk_sys);
        #1;
        chk("reset_outputs", int'({cal_load, cal_start, busy, done}), 0);
        chk("reset_para_idx", int'({cal_para, point_idx}), 0);
        @(negedge clk_sys); #1;
        rst_n = 1'b1;

`ifdef CAL_SWEEP_LOOP_EN
        // Continuous sweep 1,2,1,2... until abort.
        drive_go(1, 2, 1, 1, 0);
        repeat (30) @(negedge clk_sys);
        sweep_abort = 1'b1;
        @(posedge clk_sys); #2;
        sweep_abort = 1'b0;
        @(negedge clk_sys);
        chk("loop_abort_busy", int'(busy), 0);
        chk("loop_abort_start", int'(cal_start), 0);
        chk("loop_para0", mon_loads[0], 1);
        chk("loop_para1", mon_loads[1], 2);
        chk("loop_para2", mon_loads[2], 1);
        chk("loop_para3", mon_loads[3], 2);
        chk("loop_done_pulses", int'(mon_done >= 2), 1);
        repeat (3) @(negedge clk_sys);
`else
        // Basic sweep.
        drive_go(4, 10, 3, 5, 2);
        wait_idle(200);
        chk("basic_nloads", mon_loads.size(), 3);
        chk("basic_para0", mon_loads[0], 4);
        chk("basic_para1", mon_loads[1], 7);
        chk("basic_para2", mon_loads[2], 10);
        chk("basic_len0", mon_len[0], 5);
        chk("basic_len2", mon_len[2], 5);
        chk("basic_period", mon_rise[1] - mon_rise[0], 12);
        chk("basic_rise_lat", mon_rise[0] - mon_load_cyc[0], 3);
        chk("basic_done", mon_done, 1);
        chk("basic_idx", int'(point_idx), 2);

        // Overflow past 63.
        drive_go(60, 63, 8, 2, 1);
        wait_idle(100);
        chk("ovf_nloads", mon_loads.size(), 1);
        chk("ovf_para", mon_loads[0], 60);
        chk("ovf_done", mon_done, 1);

        // Zero step.
        drive_go(5, 30, 0, 3, 0);
        wait_idle(100);
        chk("step0_nloads", mon_loads.size(), 1);
        chk("step0_para", mon_loads[0], 5);

        // start > stop, dwell=0, settle=0.
        drive_go(20, 5, 1, 0, 0);
        wait_idle(100);
        chk("rev_nloads", mon_loads.size(), 1);
        chk("rev_para", mon_loads[0], 20);
        chk("rev_len", mon_len[0], 1);
        chk("rev_rise", mon_rise[0] - mon_load_cyc[0], 1);

        // Abort during RUN of the second point.
        drive_go(4, 10, 3, 5, 2);
        n = 0;
        do begin
            @(negedge clk_sys);
            n++;
        end while (!(cal_start && point_idx == 6'd1) && n < 100);
        chk("abort_reach_timeout", int'(n >= 100), 0);
        sweep_abort = 1'b1;
        @(posedge clk_sys); #2;
        sweep_abort = 1'b0;
        @(negedge clk_sys);
        chk("abort_start", int'(cal_start), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_para", int'(cal_para), 7);
        repeat (3) @(negedge clk_sys);
        chk("abort_no_done", mon_done, 0);

        drive_go(4, 10, 3, 5, 2);
        wait_idle(200);
        chk("restart_para0", mon_loads[0], 4);
        chk("restart_nloads", mon_loads.size(), 3);

        // Asynchronous reset mid-SETTLE.
        drive_go(9, 40, 2, 3, 6);
        @(posedge clk_sys); #2;
        chk("pre_rst_busy", int'(busy), 1);
        chk("pre_rst_para", int'(cal_para), 9);
        rst_n = 1'b0;
        #1;
        chk("rst_outputs", int'({cal_load, cal_start, busy, done}), 0);
        chk("rst_para_idx", int'({cal_para, point_idx}), 0);
        @(negedge clk_sys); #1;
        rst_n = 1'b1;

        // go and abort together in IDLE.
        @(posedge clk_sys); #2;
        para_start = 6'd3; para_stop = 6'd9; para_step = 6'd1;
        sweep_go = 1'b1; sweep_abort = 1'b1;
        @(posedge clk_sys); #2;
        sweep_go = 1'b0; sweep_abort = 1'b0;
        seen_busy = 0;
        repeat (5) begin
            @(negedge clk_sys);
            if (busy || cal_load) seen_busy = 1;
        end
        chk("go_abort_idle", int'(seen_busy), 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
